hangman_datapath: RTL
=====================

// Module: hangman_datapath
// PURPOSE
//  Datapath responder to the hangman game control FSM. Stores the secret word typed by player 1.
//  Answers guess/fill/draw/time commands from the control FSM with handshake/status flags:
//  loaded, graph_loaded, match, done, finish, complete, continuous and timeout.
//  Sits between the keyboard char decoder, the game control FSM and the VGA plotter.
// PARAMETERS
//  MAX_LEN        16          max secret word length (chars)
//  CHAR_W         8           char code width (ASCII)
//  MAX_MISS       6           misses that complete the gallows drawing
//  TICKS_PER_SEC  50_000_000  clk cycles per game second
//  TIME_LIMIT_S   99          seconds allowed per game
//  DRAW_CYC       64          cycles the plotter needs per gallows segment
// PORTS
//  clk          in   1                 system clock
//  resetn       in   1                 synchronous, active-low reset
//  char_in      in   CHAR_W            char from keyboard decoder
//  char_valid   in   1                 1-cycle strobe qualifying char_in
//  wren         in   1                 control: store char_in as next secret char
//  ld_g         in   1                 control: start game (clear mask, misses, timer)
//  compare      in   1                 control: latch char_in as guess, evaluate
//  fill         in   1                 control: reveal matching positions
//  resetchar    in   1                 control: clear latched guess
//  draw         in   1                 control: add one miss, draw segment
//  timecount    in   1                 control: run game timer
//  over         in   1                 control: end game, clear all state
//  loaded       out  1                 1-cycle ack of a stored/dropped char
//  full         out  1                 word_len == MAX_LEN
//  graph_loaded out  1                 game armed (level)
//  match        out  1                 registered result of last compare
//  done         out  1                 1-cycle: fill walk finished
//  continuous   out  1                 unrevealed positions remain (valid with done)
//  finish       out  1                 1-cycle: segment draw finished
//  complete     out  1                 miss_cnt == MAX_MISS
//  timeout      out  1                 timer expired (sticky)
//  fill_pos     out  $clog2(MAX_LEN)   position being walked; plot when fill_we
//  fill_we      out  1                 position revealed this cycle
//  reveal_mask  out  MAX_LEN           1 = position shown
//  word_len     out  $clog2(MAX_LEN+1) stored length
//  miss_cnt     out  3                 misses so far
//  sec_left     out  7                 seconds remaining
// BEHAVIOUR
//  Reset / over: word_len=0, mask=0, guess=0, miss_cnt=0, sec_left=TIME_LIMIT_S; all flags 0; FSM IDLE.
//  Priority, one command per cycle: resetn > over > ld_g > fill > draw > compare > wren.
//  wren&&char_valid: if !full, word[word_len]<=char_in and word_len++; loaded=1 on the next cycle.
//    If full, the char is dropped and loaded still pulses.
//  ld_g: mask=0, miss=0, sec_left=TIME_LIMIT_S, timeout=0; graph_loaded=1 next cycle if word_len>0.
//    graph_loaded stays 0 if word_len==0 and holds until over.
//  compare&&char_valid&&graph_loaded: guess<=char_in; match<=|(word[i]==char_in, i<word_len) next cycle.
//    A guess of an already-revealed letter gives match=1 and no miss.
//  FSM IDLE->FILL on fill: walk i=0..word_len-1, one position per cycle.
//    fill_we=1 and mask[i]<=1 where word[i]==guess.
//    After the last position -> IDLE with done=1 for 1 cycle; continuous=(mask!=all-ones over word_len), evaluated with the final update.
//    Latency = word_len+1 cycles.
//  FSM IDLE->DRAW on draw: miss_cnt++ (saturates at MAX_MISS) in the entry cycle.
//    After DRAW_CYC cycles -> IDLE with finish=1 for 1 cycle.
//  fill/draw while not IDLE are ignored; over aborts any walk immediately.
//  resetchar: guess<=0; match<=0.
//  Timer: while timecount&&graph_loaded&&!timeout, count ticks; at TICKS_PER_SEC-1 wrap and sec_left--.
//    When sec_left reaches 0, timeout=1 (sticky); it clears only on ld_g, over or reset.
//  ld_g mid-walk: FSM -> IDLE, no done pulse.
// STRUCTURE
//  Package hangman_pkg: CHAR_W, MAX_LEN, MAX_MISS, dp_state_t {IDLE,FILL,DRAW}, key code constants.
//  Sub-module game_timer (tick prescaler + seconds down-counter + sticky timeout).
//  Word RAM, mask and walk FSM live in the top.
// TESTING (TICKS_PER_SEC=4, TIME_LIMIT_S=3, DRAW_CYC=4)
//  Store "CAT" via wren+strobes -> three loaded pulses, word_len=3; 17th char -> dropped, full=1.
//  ld_g; compare 'A' -> match=1; fill -> fill_we only at pos 1, done at cycle 4, continuous=1.
//  compare 'Z' -> match=0; draw -> miss_cnt=1, finish exactly 5 cycles after draw.
//  Six draws -> complete=1; seventh draw -> miss_cnt stays 6.
//  timecount held 12 cycles -> sec_left 3->0, timeout=1; it holds with timecount low and clears on ld_g.
//  over during the fill walk -> no done; mask=0, word_len=0, graph_loaded=0 the next cycle.

Source files
------------

// File: rtl/hangman_pkg.sv
`default_nettype none
// ============================================================================
// hangman_pkg : shared sizes, datapath state encoding and key codes
// Rev 1.0
// ============================================================================
package hangman_pkg;

    localparam int CHAR_W   = 8;
    localparam int MAX_LEN  = 16;
    localparam int MAX_MISS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DRAW = 2'd2
    } dp_state_t;

    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_BKSP  = 8'h08;
    localparam logic [7:0] KEY_A     = 8'h41;
    localparam logic [7:0] KEY_Z     = 8'h5A;

endpackage
`default_nettype wire

// File: rtl/hangman_datapath_game_timer.sv
`default_nettype none
// ============================================================================
// game_timer : tick prescaler, seconds down-counter and sticky timeout
// Rev 1.0
// ============================================================================
module game_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TIME_LIMIT_S  = 99
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear_i,
    input  logic       run_i,
    output logic [6:0] sec_left_o,
    output logic       timeout_o
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [TW-1:0] tick_q;
    logic [6:0]    sec_q;
    logic          timeout_q;

    always_ff @(posedge clk) begin
        if (!resetn || clear_i) begin
            tick_q    <= '0;
            sec_q     <= 7'(TIME_LIMIT_S);
            timeout_q <= 1'b0;
        end else if (run_i && !timeout_q) begin
            if (tick_q == TW'(TICKS_PER_SEC - 1)) begin
                tick_q <= '0;
                sec_q  <= sec_q - 7'd1;
                // timeout rises on the same edge the display reaches zero
                if (sec_q == 7'd1) timeout_q <= 1'b1;
            end else begin
                tick_q <= tick_q + TW'(1);
            end
        end
    end

    assign sec_left_o = sec_q;
    assign timeout_o  = timeout_q;

endmodule
`default_nettype wire

// File: rtl/hangman_datapath.sv
`default_nettype none
// ============================================================================
// hangman_datapath : secret word store, reveal mask, fill/draw walker, timer
// Rev 1.0
// ============================================================================
module hangman_datapath
    import hangman_pkg::*;
#(
    parameter int MAX_LEN       = hangman_pkg::MAX_LEN,
    parameter int CHAR_W        = hangman_pkg::CHAR_W,
    parameter int MAX_MISS      = hangman_pkg::MAX_MISS,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TIME_LIMIT_S  = 99,
    parameter int DRAW_CYC      = 64
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [CHAR_W-1:0]            char_in_i,
    input  logic                         char_valid_i,
    input  logic                         wren_i,
    input  logic                         ld_g_i,
    input  logic                         compare_i,
    input  logic                         fill_i,
    input  logic                         resetchar_i,
    input  logic                         draw_i,
    input  logic                         timecount_i,
    input  logic                         over_i,
    output logic                         loaded_o,
    output logic                         full_o,
    output logic                         graph_loaded_o,
    output logic                         match_o,
    output logic                         done_o,
    output logic                         continuous_o,
    output logic                         finish_o,
    output logic                         complete_o,
    output logic                         timeout_o,
    output logic [$clog2(MAX_LEN)-1:0]   fill_pos_o,
    output logic                         fill_we_o,
    output logic [MAX_LEN-1:0]           reveal_mask_o,
    output logic [$clog2(MAX_LEN+1)-1:0] word_len_o,
    output logic [2:0]                   miss_cnt_o,
    output logic [6:0]                   sec_left_o
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int DW = $clog2(DRAW_CYC + 1);

    logic [CHAR_W-1:0]  word_q [MAX_LEN];
    logic [LW-1:0]      word_len_q;
    logic [LW-1:0]      walk_idx_q;
    logic [MAX_LEN-1:0] mask_q;
    logic [CHAR_W-1:0]  guess_q;
    logic [DW-1:0]      draw_cnt_q;
    logic [2:0]         miss_cnt_q;
    logic [PW-1:0]      fill_pos_q;
    dp_state_t          state_q;
    logic               loaded_q, graph_loaded_q, match_q, done_q;
    logic               continuous_q, finish_q, fill_we_q;

    logic [MAX_LEN-1:0] w_in_len;
    logic [MAX_LEN-1:0] w_hit;
    logic               w_full, w_store, w_walk_hit;

    generate
        for (genvar i = 0; i < MAX_LEN; i++) begin : g_pos
            assign w_in_len[i] = (LW'(i) < word_len_q);
            assign w_hit[i]    = w_in_len[i] && (word_q[i] == char_in_i);
        end
    endgenerate

    assign w_full     = (word_len_q == LW'(MAX_LEN));
    assign w_walk_hit = (word_q[walk_idx_q[PW-1:0]] == guess_q);
    // wren wins only when no higher-priority command is present
    assign w_store    = !over_i && !ld_g_i && !fill_i && !draw_i && !compare_i &&
                        wren_i && char_valid_i && !w_full;

    always_ff @(posedge clk) begin
        if (resetn && w_store) word_q[word_len_q[PW-1:0]] <= char_in_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn || over_i) begin
            word_len_q     <= '0;
            walk_idx_q     <= '0;
            mask_q         <= '0;
            guess_q        <= '0;
            draw_cnt_q     <= '0;
            miss_cnt_q     <= '0;
            fill_pos_q     <= '0;
            state_q        <= IDLE;
            loaded_q       <= 1'b0;
            graph_loaded_q <= 1'b0;
            match_q        <= 1'b0;
            done_q         <= 1'b0;
            continuous_q   <= 1'b0;
            finish_q       <= 1'b0;
            fill_we_q      <= 1'b0;
        end else begin
            loaded_q  <= 1'b0;
            done_q    <= 1'b0;
            finish_q  <= 1'b0;
            fill_we_q <= 1'b0;
            if (ld_g_i) begin
                mask_q         <= '0;
                miss_cnt_q     <= '0;
                graph_loaded_q <= (word_len_q != '0);
                state_q        <= IDLE;
            end else begin
                case (state_q)
                    FILL: begin
                        if (walk_idx_q < word_len_q) begin
                            fill_pos_q <= walk_idx_q[PW-1:0];
                            walk_idx_q <= walk_idx_q + LW'(1);
                            if (w_walk_hit) begin
                                mask_q[walk_idx_q[PW-1:0]] <= 1'b1;
                                fill_we_q                  <= 1'b1;
                            end
                        end else begin
                            // mask already holds the last position's update here
                            state_q      <= IDLE;
                            done_q       <= 1'b1;
                            continuous_q <= |(~mask_q & w_in_len);
                        end
                    end
                    DRAW: begin
                        if (draw_cnt_q == DW'(DRAW_CYC)) begin
                            state_q  <= IDLE;
                            finish_q <= 1'b1;
                        end else begin
                            draw_cnt_q <= draw_cnt_q + DW'(1);
                        end
                    end
                    default: begin
                        if (fill_i) begin
                            state_q    <= FILL;
                            walk_idx_q <= '0;
                        end else if (draw_i) begin
                            state_q    <= DRAW;
                            draw_cnt_q <= '0;
                            if (miss_cnt_q != 3'(MAX_MISS)) miss_cnt_q <= miss_cnt_q + 3'd1;
                        end
                    end
                endcase

                if (!fill_i && !draw_i) begin
                    if (compare_i) begin
                        if (char_valid_i && graph_loaded_q) begin
                            guess_q <= char_in_i;
                            match_q <= |w_hit;
                        end
                    end else if (wren_i) begin
                        loaded_q <= char_valid_i;
                        if (w_store) word_len_q <= word_len_q + LW'(1);
                    end else if (resetchar_i) begin
                        guess_q <= '0;
                        match_q <= 1'b0;
                    end
                end
            end
        end
    end

    game_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .TIME_LIMIT_S  (TIME_LIMIT_S)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .clear_i    (ld_g_i || over_i),
        .run_i      (timecount_i && graph_loaded_q),
        .sec_left_o (sec_left_o),
        .timeout_o  (timeout_o)
    );

    assign loaded_o       = loaded_q;
    assign full_o         = w_full;
    assign graph_loaded_o = graph_loaded_q;
    assign match_o        = match_q;
    assign done_o         = done_q;
    assign continuous_o   = continuous_q;
    assign finish_o       = finish_q;
    assign complete_o     = (miss_cnt_q == 3'(MAX_MISS));
    assign fill_pos_o     = fill_pos_q;
    assign fill_we_o      = fill_we_q;
    assign reveal_mask_o  = mask_q;
    assign word_len_o     = word_len_q;
    assign miss_cnt_o     = miss_cnt_q;

endmodule
`default_nettype wire
